// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding / load-use hazard controller.
// The optional stall counter is enabled by defining FWD_STALL_CNT_EN.
package fwd_pkg;

    localparam int FWD_REG_ADDR_W  = 5;
    localparam int FWD_STALL_CNT_W = 32;

    typedef enum logic [1:0] {
        FWD_SEL_RF    = 2'd0,
        FWD_SEL_EXMEM = 2'd1,
        FWD_SEL_MEMWB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request / forwarding-select bundle between pipeline control and the hazard block.
// stall_cnt exists only when FWD_STALL_CNT_EN is defined.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_W = fwd_pkg::FWD_REG_ADDR_W
`ifdef FWD_STALL_CNT_EN
    ,
    parameter int STALL_CNT_W = fwd_pkg::FWD_STALL_CNT_W
`endif
);
    import fwd_pkg::*;

    logic                  pipe_en;
    logic                  flush;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    fwd_sel_t              fwd_a_sel;
    fwd_sel_t              fwd_b_sel;
    logic                  stall;
`ifdef FWD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`endif

    modport master (
        output pipe_en, flush, id_rs1, id_rs2, id_use_rs2, id_rd, id_reg_write, id_mem_read,
        input  fwd_a_sel, fwd_b_sel, stall
`ifdef FWD_STALL_CNT_EN
        , stall_cnt
`endif
    );

    modport slave (
        input  pipe_en, flush, id_rs1, id_rs2, id_use_rs2, id_rd, id_reg_write, id_mem_read,
        output fwd_a_sel, fwd_b_sel, stall
`ifdef FWD_STALL_CNT_EN
        , stall_cnt
`endif
    );

endinterface

// File: rtl/fwd_hazard_ctrl_src_match.sv
// Priority compare of one ID source register against the EX and MEM destination shadows.
// The younger EX/MEM producer wins; x0 is never forwarded.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = FWD_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_we,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_we,
    output fwd_sel_t              sel
);

    always_comb begin
        sel = FWD_SEL_RF;
        if (ex_we && (ex_rd != '0) && (ex_rd == src)) begin
            sel = FWD_SEL_EXMEM;
        end else if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_SEL_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage pipeline.
// Define FWD_STALL_CNT_EN to add the free-running stall_cnt output.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = FWD_REG_ADDR_W
`ifdef FWD_STALL_CNT_EN
    ,
    parameter int STALL_CNT_W = FWD_STALL_CNT_W
`endif
) (
    input logic              clk,
    input logic              arst_n,
    fwd_hazard_ctrl_if.slave bus
);

    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_we;
    logic                  ex_ld;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_we;
    fwd_sel_t              a_sel_d;
    fwd_sel_t              b_sel_d;
    fwd_sel_t              a_sel_q;
    fwd_sel_t              b_sel_q;
    logic                  load_hit;
    logic                  stall;

    fwd_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
        .src    (bus.id_rs1),
        .ex_rd  (ex_rd),
        .ex_we  (ex_we),
        .mem_rd (mem_rd),
        .mem_we (mem_we),
        .sel    (a_sel_d)
    );

    fwd_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
        .src    (bus.id_rs2),
        .ex_rd  (ex_rd),
        .ex_we  (ex_we),
        .mem_rd (mem_rd),
        .mem_we (mem_we),
        .sel    (b_sel_d)
    );

    // A load result is not available until MEM, so a consumer right behind it waits one cycle.
    // Frozen or killed ID instructions never stall, so a bubble is inserted exactly once.
    assign load_hit = ex_ld && ex_we && (ex_rd != '0) &&
                      ((ex_rd == bus.id_rs1) || (bus.id_use_rs2 && (ex_rd == bus.id_rs2)));
    assign stall    = bus.pipe_en && !bus.flush && load_hit;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            ex_rd   <= '0;
            ex_we   <= 1'b0;
            ex_ld   <= 1'b0;
            mem_rd  <= '0;
            mem_we  <= 1'b0;
            a_sel_q <= FWD_SEL_RF;
            b_sel_q <= FWD_SEL_RF;
        end else if (bus.pipe_en) begin
            mem_rd <= ex_rd;
            mem_we <= ex_we;
            if (bus.flush || stall) begin
                ex_rd   <= '0;
                ex_we   <= 1'b0;
                ex_ld   <= 1'b0;
                a_sel_q <= FWD_SEL_RF;
                b_sel_q <= FWD_SEL_RF;
            end else begin
                ex_rd   <= bus.id_rd;
                ex_we   <= bus.id_reg_write;
                ex_ld   <= bus.id_mem_read;
                a_sel_q <= a_sel_d;
                b_sel_q <= b_sel_d;
            end
        end
    end

    assign bus.fwd_a_sel = a_sel_q;
    assign bus.fwd_b_sel = b_sel_q;
    assign bus.stall     = stall;

`ifdef FWD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    // stall is already low while frozen, so the counter holds without an extra enable.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Testbench for fwd_hazard_ctrl: directed instruction-sequence table, load-use counter run,
// then random traffic against an in-flight instruction queue model (FWD_STALL_CNT_EN aware).
module tb_fwd_hazard_ctrl;

    logic clk = 1'b0;
    logic arst_n;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

    fwd_hazard_ctrl #(.REG_ADDR_W(5)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       pe;
        logic       fl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       exp_stall;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } slot_t;

    vec_t        tbl[$];
    slot_t       pipe_q[$];
    logic [1:0]  m_a;
    logic [1:0]  m_b;
    int unsigned m_cnt;

    function automatic vec_t mk(input logic rst, pe, fl, input logic [4:0] rs1, rs2,
                                input logic use2, input logic [4:0] rd, input logic we, ld,
                                input logic es, input logic [1:0] ea, eb);
        vec_t v;
        v.rst = rst; v.pe = pe; v.fl = fl; v.rs1 = rs1; v.rs2 = rs2; v.use2 = use2;
        v.rd = rd; v.we = we; v.ld = ld; v.exp_stall = es; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    // Model: index 0 is the instruction in EX, index 1 the one in MEM.
    function automatic void model_reset();
        slot_t b;
        b.rd = '0; b.we = 1'b0; b.ld = 1'b0;
        pipe_q = {};
        pipe_q.push_back(b);
        pipe_q.push_back(b);
        m_a   = 2'd0;
        m_b   = 2'd0;
        m_cnt = 0;
    endfunction

    function automatic logic [1:0] model_sel(input logic [4:0] s);
        for (int age = 0; age < pipe_q.size(); age++) begin
            if (pipe_q[age].we && pipe_q[age].rd != 5'd0 && pipe_q[age].rd == s)
                return (age == 0) ? 2'd1 : 2'd2;
        end
        return 2'd0;
    endfunction

    function automatic logic model_stall();
        slot_t e;
        e = pipe_q[0];
        return bus.pipe_en && !bus.flush && e.ld && e.we && e.rd != 5'd0 &&
               (e.rd == bus.id_rs1 || (bus.id_use_rs2 && e.rd == bus.id_rs2));
    endfunction

    function automatic void model_edge(input logic rst);
        slot_t nxt;
        logic  st;
        if (rst) begin
            model_reset();
        end else if (bus.pipe_en) begin
            st = model_stall();
            if (st) m_cnt++;
            if (bus.flush || st) begin
                nxt.rd = '0; nxt.we = 1'b0; nxt.ld = 1'b0;
                m_a = 2'd0;
                m_b = 2'd0;
            end else begin
                m_a = model_sel(bus.id_rs1);
                m_b = model_sel(bus.id_rs2);
                nxt.rd = bus.id_rd; nxt.we = bus.id_reg_write; nxt.ld = bus.id_mem_read;
            end
            pipe_q.push_front(nxt);
            void'(pipe_q.pop_back());
        end
    endfunction

    task automatic apply_stimulus(input logic pe, fl, input logic [4:0] rs1, rs2,
                                  input logic use2, input logic [4:0] rd, input logic we, ld);
        bus.pipe_en      = pe;
        bus.flush        = fl;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_use_rs2   = use2;
        bus.id_rd        = rd;
        bus.id_reg_write = we;
        bus.id_mem_read  = ld;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One pipeline cycle: drive, check before the edge, then advance model and DUT together.
    task automatic do_cycle(input string tag, input vec_t v);
        arst_n = !v.rst;
        apply_stimulus(v.pe, v.fl, v.rs1, v.rs2, v.use2, v.rd, v.we, v.ld);
        @(negedge clk);
        check_output({tag, " stall"}, 32'(bus.stall), 32'(v.exp_stall));
        check_output({tag, " fwd_a_sel"}, 32'(bus.fwd_a_sel), 32'(v.exp_a));
        check_output({tag, " fwd_b_sel"}, 32'(bus.fwd_b_sel), 32'(v.exp_b));
        model_edge(v.rst);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        // add x5; sub x6,x5,x7
        tbl.push_back(mk(0,1,0, 1,2,1, 5,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 5,7,1, 6,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,0));
        // add x5; nop; or x8,x1,x5
        tbl.push_back(mk(0,1,0, 1,2,1, 5,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 1,5,1, 8,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,2));
        // write x0 then read x0
        tbl.push_back(mk(0,1,0, 1,0,0, 0,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,1, 11,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,0));
        // lw x9; add x10,x9,x9
        tbl.push_back(mk(0,1,0, 2,0,0, 9,1,1, 0,0,0));
        tbl.push_back(mk(0,1,0, 9,9,1, 10,1,0, 1,0,0));
        tbl.push_back(mk(0,1,0, 9,9,1, 10,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,2,2));
        // same pair, consumer flushed in the stall cycle
        tbl.push_back(mk(0,1,0, 2,0,0, 9,1,1, 0,0,0));
        tbl.push_back(mk(0,1,1, 9,9,1, 10,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,0));
        // load-use with a 3-cycle freeze, then freeze while selects are nonzero
        tbl.push_back(mk(0,1,0, 2,0,0, 9,1,1, 0,0,0));
        tbl.push_back(mk(0,0,0, 9,9,1, 10,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0, 9,9,1, 10,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0, 9,9,1, 10,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 9,9,1, 10,1,0, 1,0,0));
        tbl.push_back(mk(0,1,0, 9,9,1, 10,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,2,2));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,2,2));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,2,2));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,0));
        // sources matching different stages
        tbl.push_back(mk(0,1,0, 1,2,1, 5,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 1,2,1, 6,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 6,5,1, 7,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,1,2));
        // back-to-back writers of x5
        tbl.push_back(mk(0,1,0, 1,2,1, 5,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 1,2,1, 5,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 5,5,1, 1,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,1,1));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,0));
        // load-use through rs2, with and without id_use_rs2
        tbl.push_back(mk(0,1,0, 0,0,0, 12,1,1, 0,0,0));
        tbl.push_back(mk(0,1,0, 1,12,1, 13,1,0, 1,0,0));
        tbl.push_back(mk(0,1,0, 1,12,1, 13,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,2));
        tbl.push_back(mk(0,1,0, 0,0,0, 12,1,1, 0,0,0));
        tbl.push_back(mk(0,1,0, 1,12,0, 13,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,1));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,0));
        // reset with writers of x6/x7 in flight
        tbl.push_back(mk(0,1,0, 1,2,1, 5,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 1,2,1, 6,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 6,5,1, 7,1,0, 0,0,0));
        tbl.push_back(mk(1,1,0, 0,0,0, 0,0,0, 0,1,2));
        tbl.push_back(mk(0,1,0, 7,6,1, 8,1,0, 0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0, 0,0,0));

        arst_n = 1'b0;
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
`ifdef FWD_STALL_CNT_EN
        check_output("stall_cnt after reset", bus.stall_cnt, 32'd0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            do_cycle($sformatf("row%0d", i), tbl[i]);
        end

        // four load-use pairs after a fresh reset
        do_cycle("cnt reset", mk(1,1,0, 0,0,0, 0,0,0, 0,0,0));
`ifdef FWD_STALL_CNT_EN
        check_output("stall_cnt cleared", bus.stall_cnt, 32'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            do_cycle($sformatf("lu%0d lw", k),   mk(0,1,0, 0,0,0, 9,1,1, 0,0,0));
            do_cycle($sformatf("lu%0d use", k),  mk(0,1,0, 9,9,1, 10,1,0, 1,0,0));
            do_cycle($sformatf("lu%0d held", k), mk(0,1,0, 9,9,1, 10,1,0, 0,0,0));
            do_cycle($sformatf("lu%0d ex", k),   mk(0,1,0, 0,0,0, 0,0,0, 0,2,2));
        end
`ifdef FWD_STALL_CNT_EN
        check_output("stall_cnt after 4 pairs", bus.stall_cnt, 32'd4);
`endif

        // random traffic with small register range to provoke hazards
        for (int n = 0; n < 400; n++) begin
            v.rst  = ($urandom_range(0, 39) == 0);
            v.pe   = ($urandom_range(0, 9) != 0);
            v.fl   = ($urandom_range(0, 6) == 0);
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.use2 = 1'($urandom_range(0, 1));
            v.rd   = 5'($urandom_range(0, 3));
            v.we   = ($urandom_range(0, 3) != 0);
            v.ld   = ($urandom_range(0, 2) == 0);
            arst_n = !v.rst;
            apply_stimulus(v.pe, v.fl, v.rs1, v.rs2, v.use2, v.rd, v.we, v.ld);
            @(negedge clk);
            check_output($sformatf("rnd%0d stall", n), 32'(bus.stall), 32'(model_stall()));
            check_output($sformatf("rnd%0d fwd_a_sel", n), 32'(bus.fwd_a_sel), 32'(m_a));
            check_output($sformatf("rnd%0d fwd_b_sel", n), 32'(bus.fwd_b_sel), 32'(m_b));
            model_edge(v.rst);
            @(posedge clk);
            #1;
        end
`ifdef FWD_STALL_CNT_EN
        check_output("stall_cnt random", bus.stall_cnt, m_cnt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage pipeline.
- Sits directly upstream of the two ALU-operand 3-input forwarding muxes and drives their 2-bit selects.
- Shadows the destination-register info of EX/MEM and MEM/WB internally, so it needs only ID-stage inputs.
- Registers the selects so they are valid during the consumer's EX cycle, and raises a load-use stall toward the IF/ID front end.

Parameters:
- REG_ADDR_W, 5, register-index width.
- STALL_CNT_W, 32, width of the optional stall counter.

Ports:
- clk  input  1  clock, rising edge.
- arst_n  input  1  reset; synchronous, active-low.
- pipe_en  input  1  1 = pipeline advances this cycle; 0 = global freeze (memory wait).
- flush  input  1  1 = instruction currently in ID is killed (taken branch).
- id_rs1  input  REG_ADDR_W  ID instruction source 1.
- id_rs2  input  REG_ADDR_W  ID instruction source 2.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  REG_ADDR_W  ID instruction destination.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- fwd_a_sel  output  2  select for ALU operand A mux (registered).
- fwd_b_sel  output  2  select for ALU operand B mux (registered).
- stall  output  1  hold PC and IF/ID, insert bubble into EX (combinational).

Behaviour:
- Select encoding:
  - 0 = register-file value.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB writeback data (ALU result or load data).
  - 3 is never driven.
- Internal state:
  - ex_rd, ex_we, ex_ld: shadow of the instruction in EX.
  - mem_rd, mem_we: shadow of the instruction in MEM.
- Reset (arst_n low at a rising edge): all shadow state 0; fwd_a_sel = fwd_b_sel = 0; stall = 0.
  - Reset mid-operation discards all tracked instructions immediately.
- stall (combinational) = pipe_en & !flush & ex_ld & ex_we & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
- Select computation for source s (rs1 -> A, rs2 -> B):
  - 1 if ex_we & ex_rd != 0 & ex_rd == s.
  - else 2 if mem_we & mem_rd != 0 & mem_rd == s.
  - else 0.
  - EX/MEM has priority over MEM/WB.
  - Register x0 is never forwarded.
- Rising edge with pipe_en = 1:
  - mem_* <= ex_* (ex_ld dropped).
  - If flush or stall: ex_* <= 0 (bubble) and both selects <= 0.
  - Otherwise: ex_* <= {id_rd, id_reg_write, id_mem_read}, and selects <= the values computed from id_rs1/id_rs2 against the pre-edge ex_*/mem_*.
- Rising edge with pipe_en = 0: all state and selects hold. stall is forced 0, so no bubble is double-counted.
- Latency:
  - Selects are valid exactly one cycle after the consumer was in ID, i.e. during its EX cycle.
  - stall is same-cycle.
- Load-use sequence:
  - Cycle t: stall = 1 (load in EX, consumer in ID).
  - Cycle t+1: stall = 0; the consumer is matched against the load, now in MEM.
  - The consumer enters EX with sel = 2.
- flush has priority over stall: the killed instruction cannot cause a stall.
- A back-to-back writer pair to the same rd forwards from the younger writer (sel = 1).
- Two sources matching different stages get independent selects.
- The ID-stage read of a register being written back in the same cycle is covered by register-file write-through, not by this block.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [STALL_CNT_W-1:0].
  - Reset value 0.
  - Increments on every rising edge where stall = 1.
  - Wraps at 2^STALL_CNT_W - 1 -> 0.
  - Holds when pipe_en = 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fwd_pkg:
  - FWD_SEL_RF = 2'd0, FWD_SEL_EXMEM = 2'd1, FWD_SEL_MEMWB = 2'd2.
  - fwd_sel_t (2-bit) typedef.
  - REG_ADDR_W default constant.
- Sub-module fwd_src_match: one instance per source.
  - Inputs: src, ex_rd/ex_we, mem_rd/mem_we.
  - Outputs: 2-bit select.
  - Purely combinational priority compare.

Test Plan:
- add x5 then sub x6,x5,x7 back-to-back -> fwd_a_sel = 1 in the sub's EX cycle, fwd_b_sel = 0, stall = 0.
- add x5; nop; or x8,x1,x5 -> fwd_b_sel = 2 during the or's EX cycle; a write to x0 followed by a read of x0 -> sel = 0.
- lw x9 then add x10,x9,x9 -> stall = 1 for exactly one cycle, then fwd_a_sel = fwd_b_sel = 2; the same pair with a flush in the stall cycle -> stall = 0 and selects = 0.
- pipe_en held 0 for 3 cycles in the middle of the load-use case -> stall = 0 during the freeze, state and selects held, and the sequence resumes unchanged.
- arst_n asserted with a writer in EX and in MEM -> next consumer of the same rd gets sel = 0; with FWD_STALL_CNT_EN, stall_cnt = 0 after reset and 4 after four load-use pairs.
